// File: rtl/mac_result_serializer_pkg.sv
// mac_ser_pkg: shared types and constants for the MAC result serializer.
// Holds the FSM state encoding, the default result width, and the bit-counter width helper.
// The optional parity beat (MAC_SER_PARITY_EN) uses the PAR encoding defined here.
package mac_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_t;

  localparam int MAC_SER_WIDTH = 16;

  // The counter indexes bits 0..w-1, so log2 of the width is enough; never below one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mac_result_serializer_if.sv
// Handshake bundle between the accumulator bank, the serializer and the serial sink.
// No logic or latency; pure wiring.
// The master modport is the environment side; the slave modport is the serializer side.
interface mac_result_serializer_if
  import mac_ser_pkg::*;
#(
  parameter int WIDTH = MAC_SER_WIDTH
);
  logic [WIDTH-1:0] acc_in;
  logic             acc_valid;
  logic             acc_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic             busy;

  modport master (
    output acc_in, acc_valid, ser_ready,
    input  acc_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  acc_in, acc_valid, ser_ready,
    output acc_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/mac_result_serializer.sv
// Purpose: capture a parallel accumulator result and stream it LSB first, one bit per accepted beat.
// Latency: first bit valid 1 cycle after capture; WIDTH beats per frame (WIDTH+1 with MAC_SER_PARITY_EN).
// Backpressure: ser_ready=0 freezes bit, last flag and all state; acc_ready is high only when idle.
module mac_result_serializer
  import mac_ser_pkg::*;
#(
  parameter  int WIDTH = MAC_SER_WIDTH,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic                  CLK,
  input  logic                  CLR,
  mac_result_serializer_if.slave bus
);

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
`ifdef MAC_SER_PARITY_EN
  logic             r_par;
`endif

  logic w_acc_ready;
  logic w_ser_valid;
  logic w_ser_out;
  logic w_ser_last;
  logic w_busy;
  logic w_last_bit;
  logic w_capture;
  logic w_data_beat;

  assign w_last_bit  = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_capture   = bus.acc_valid & w_acc_ready;
  assign w_data_beat = (r_state == SHIFT) & bus.ser_ready;

  // State register: reset returns to IDLE and abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (CLR) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: leave IDLE on capture, leave SHIFT on the accepted final data beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_capture) w_state_nxt = SHIFT;
      SHIFT: if (bus.ser_ready && w_last_bit) begin
`ifdef MAC_SER_PARITY_EN
               w_state_nxt = PAR;
`else
               w_state_nxt = IDLE;
`endif
             end
`ifdef MAC_SER_PARITY_EN
      PAR:   if (bus.ser_ready) w_state_nxt = IDLE;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load on capture, shift on each accepted data beat; counter pins at the last bit.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_shreg <= '0;
      r_cnt   <= '0;
`ifdef MAC_SER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_capture) begin
      r_shreg <= bus.acc_in;
      r_cnt   <= '0;
`ifdef MAC_SER_PARITY_EN
      r_par   <= ^bus.acc_in;
`endif
    end else if (w_data_beat) begin
      r_shreg <= r_shreg >> 1;
      if (!w_last_bit) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Outputs: decoded from state only; acc_ready is additionally masked while CLR is high.
  always_comb begin
    w_acc_ready = 1'b0;
    w_ser_valid = 1'b0;
    w_ser_out   = 1'b0;
    w_ser_last  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: w_acc_ready = ~CLR;
      SHIFT: begin
        w_ser_valid = 1'b1;
        w_busy      = 1'b1;
        w_ser_out   = r_shreg[0];
`ifdef MAC_SER_PARITY_EN
        w_ser_last  = 1'b0;
`else
        w_ser_last  = w_last_bit;
`endif
      end
`ifdef MAC_SER_PARITY_EN
      PAR: begin
        w_ser_valid = 1'b1;
        w_busy      = 1'b1;
        w_ser_out   = r_par;
        w_ser_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.acc_ready = w_acc_ready;
  assign bus.ser_valid = w_ser_valid;
  assign bus.ser_out   = w_ser_out;
  assign bus.ser_last  = w_ser_last;
  assign bus.busy      = w_busy;

endmodule
